// File: rtl/pipe_pkg_rv32.sv
// pipe_pkg_rv32: shared FSM encoding, scoreboard entry type and default sizes for pipe_ctrl_rv32.
package pipe_pkg_rv32;
  localparam int NSTAGES_DEF = 5;
  localparam int REGW_DEF = 5;
  localparam int REGW_MAX = 8;
  typedef enum logic [1:0] {RUN, HAZ, FLUSH, FRZ} state_t;
  // rd is held at REGW_MAX bits so one entry type serves every legal REGW
  typedef struct packed {
    logic                valid;
    logic [REGW_MAX-1:0] rd;
    logic                load;
  } sb_entry_t;
endpackage

// File: rtl/pipe_ctrl_rv32_if.sv
// pipe_ctrl_rv32_if: ID issue / stall inputs and pipeline control outputs of pipe_ctrl_rv32.
interface pipe_ctrl_rv32_if #(parameter int NSTAGES = 5, parameter int REGW = 5, parameter int CNTW = 16);
  logic              iIssueValid;
  logic [REGW-1:0]   iIssueRs1;
  logic [REGW-1:0]   iIssueRs2;
  logic              iUseRs1;
  logic              iUseRs2;
  logic [REGW-1:0]   iIssueRd;
  logic              iIssueLoad;
  logic              iBranch;
  logic              iStallI;
  logic              iStallD;
  logic              oHoldIF;
  logic              oHoldID;
  logic              oBubbleEX;
  logic              oFlush;
  logic [NSTAGES-3:0] oValid;
  logic [CNTW-1:0]   oStallCnt;
  modport slave (
    input  iIssueValid, iIssueRs1, iIssueRs2, iUseRs1, iUseRs2, iIssueRd, iIssueLoad,
           iBranch, iStallI, iStallD,
    output oHoldIF, oHoldID, oBubbleEX, oFlush, oValid, oStallCnt
  );
  modport master (
    output iIssueValid, iIssueRs1, iIssueRs2, iUseRs1, iUseRs2, iIssueRd, iIssueLoad,
           iBranch, iStallI, iStallD,
    input  oHoldIF, oHoldID, oBubbleEX, oFlush, oValid, oStallCnt
  );
endinterface

// File: rtl/sb_match_rv32.sv
// sb_match_rv32: per-entry source-register match vectors against the in-flight scoreboard.
module sb_match_rv32 import pipe_pkg_rv32::*; #(
  parameter int N    = 3,
  parameter int REGW = REGW_DEF
) (
  input  sb_entry_t [N-1:0] i_sb,
  input  logic [REGW-1:0]   i_rs1,
  input  logic [REGW-1:0]   i_rs2,
  input  logic              i_use1,
  input  logic              i_use2,
  output logic [N-1:0]      o_m1,
  output logic [N-1:0]      o_m2
);
  for (genvar k = 0; k < N; k++) begin : g_m
    assign o_m1[k] = i_use1 & i_sb[k].valid & (i_sb[k].rd != '0) & (i_sb[k].rd == REGW_MAX'(i_rs1));
    assign o_m2[k] = i_use2 & i_sb[k].valid & (i_sb[k].rd != '0) & (i_sb[k].rd == REGW_MAX'(i_rs2));
  end
endmodule

// File: rtl/pipe_ctrl_rv32.sv
// pipe_ctrl_rv32: RV32 pipeline hazard/stall/flush controller with scoreboard and stall counter.
// PIPE_CTRL_FWD_EN: bypass present, only load-use stalls; undefined: stall until producer reaches WB.
module pipe_ctrl_rv32 import pipe_pkg_rv32::*; #(
  parameter int NSTAGES = NSTAGES_DEF,
  parameter int REGW    = REGW_DEF,
  parameter int CNTW    = 16
) (
  input logic iCLK,
  input logic iRST,
  pipe_ctrl_rv32_if.slave bus
);
  localparam int N = NSTAGES - 2;
  sb_entry_t [N-1:0] r_sb;
  sb_entry_t         w_e0;
  state_t            r_state, w_next;
  logic [CNTW-1:0]   r_cnt;
  logic [N-1:0]      w_m1, w_m2;
  logic w_raw, w_br, w_hz, w_adv, w_hold_if, w_hold_id, w_bubble, w_flush, w_unused;
  sb_match_rv32 #(.N(N), .REGW(REGW)) u_match (
    .i_sb(r_sb), .i_rs1(bus.iIssueRs1), .i_rs2(bus.iIssueRs2),
    .i_use1(bus.iUseRs1), .i_use2(bus.iUseRs2), .o_m1(w_m1), .o_m2(w_m2)
  );
`ifdef PIPE_CTRL_FWD_EN
  assign w_raw = (w_m1[0] | w_m2[0]) & r_sb[0].load;
`else
  assign w_raw = |((w_m1 | w_m2) & {1'b0, {(N-1){1'b1}}});
`endif
  always_comb begin
    w_unused = ^{w_m1, w_m2};
    for (int k = 0; k < N; k++) w_unused = w_unused ^ r_sb[k].load;
  end
  // EX holds a bubble while in FLUSH, so a branch there cannot be real
  assign w_br = bus.iBranch & ~bus.iStallD & (r_state != FLUSH);
  assign w_hz = w_raw & ~bus.iStallD & ~w_br;
  always_comb begin
    w_hold_if = 1'b0;
    w_hold_id = 1'b0;
    w_bubble  = 1'b0;
    w_flush   = 1'b0;
    w_adv     = 1'b1;
    w_next    = RUN;
    if (!iRST) begin
      w_bubble = 1'b1;
      w_flush  = 1'b1;
    end else if (bus.iStallD) begin
      w_hold_if = 1'b1;
      w_hold_id = 1'b1;
      w_adv     = 1'b0;
      w_next    = FRZ;
    end else if (w_br) begin
      w_bubble = 1'b1;
      w_flush  = 1'b1;
      w_next   = FLUSH;
    end else if (w_hz) begin
      w_hold_if = 1'b1;
      w_hold_id = 1'b1;
      w_bubble  = 1'b1;
      w_next    = HAZ;
    end else if (bus.iStallI) begin
      w_hold_if = 1'b1;
      w_bubble  = 1'b1;
    end
  end
  assign w_e0 = '{valid: bus.iIssueValid & ~w_bubble & ~w_flush,
                  rd: REGW_MAX'(bus.iIssueRd), load: bus.iIssueLoad};
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      r_state <= RUN;
      r_sb    <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if (w_adv) r_sb <= {r_sb[N-2:0], w_e0};
      if (w_hz && r_cnt != '1) r_cnt <= r_cnt + 1'b1;
    end
  end
  always_comb begin
    bus.oValid = '0;
    for (int k = 0; k < N; k++) bus.oValid[k] = r_sb[k].valid;
  end
  assign bus.oHoldIF   = w_hold_if;
  assign bus.oHoldID   = w_hold_id;
  assign bus.oBubbleEX = w_bubble;
  assign bus.oFlush    = w_flush;
  assign bus.oStallCnt = r_cnt;
endmodule

// File: tb/tb_pipe_ctrl_rv32.sv
// tb_pipe_ctrl_rv32: scoreboard bench for pipe_ctrl_rv32 (default sizes plus a CNTW=2 copy for saturation).
module tb_pipe_ctrl_rv32;
  logic iCLK = 1'b0;
  logic iRST = 1'b1;
  always #5 iCLK = ~iCLK;
  pipe_ctrl_rv32_if u_if ();
  pipe_ctrl_rv32_if #(.CNTW(2)) u_if2 ();
  pipe_ctrl_rv32 dut (.iCLK(iCLK), .iRST(iRST), .bus(u_if.slave));
  pipe_ctrl_rv32 #(.CNTW(2)) dut2 (.iCLK(iCLK), .iRST(iRST), .bus(u_if2.slave));
`ifdef PIPE_CTRL_FWD_EN
  localparam int HZ_CYC = 1;
`else
  localparam int HZ_CYC = 2;
`endif
  logic       s_valid, s_ld, s_u1, s_u2, s_br, s_si, s_sd;
  logic [4:0] s_rd, s_rs1, s_rs2;
  always_comb begin
    u_if.iIssueValid = s_valid;  u_if2.iIssueValid = s_valid;
    u_if.iIssueRd    = s_rd;     u_if2.iIssueRd    = s_rd;
    u_if.iIssueLoad  = s_ld;     u_if2.iIssueLoad  = s_ld;
    u_if.iIssueRs1   = s_rs1;    u_if2.iIssueRs1   = s_rs1;
    u_if.iUseRs1     = s_u1;     u_if2.iUseRs1     = s_u1;
    u_if.iIssueRs2   = s_rs2;    u_if2.iIssueRs2   = s_rs2;
    u_if.iUseRs2     = s_u2;     u_if2.iUseRs2     = s_u2;
    u_if.iBranch     = s_br;     u_if2.iBranch     = s_br;
    u_if.iStallI     = s_si;     u_if2.iStallI     = s_si;
    u_if.iStallD     = s_sd;     u_if2.iStallD     = s_sd;
  end
  typedef struct {
    logic [3:0] ctrl;
    logic [2:0] vld;
    int         cnt;
  } exp_t;
  exp_t q[$];
  int checks = 0;
  int failures = 0;
  logic [2:0] ev = 3'b000;
  int exp_cnt = 0;
  wire [3:0] ctrl = {u_if.oHoldIF, u_if.oHoldID, u_if.oBubbleEX, u_if.oFlush};
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic drv(input logic v, input logic [4:0] rd, input logic ld, input logic [4:0] rs1,
                     input logic u1, input logic [4:0] rs2, input logic u2,
                     input logic br, input logic si, input logic sd);
    s_valid = v; s_rd = rd; s_ld = ld; s_rs1 = rs1; s_u1 = u1;
    s_rs2 = rs2; s_u2 = u2; s_br = br; s_si = si; s_sd = sd;
  endtask
  // ctrl expectation is {oHoldIF, oHoldID, oBubbleEX, oFlush}; nb is the valid bit entering EX
  task automatic cyc(input string tag, input logic [3:0] ce, input logic nb);
    exp_t e;
    if (ce != 4'b1100) ev = {ev[1:0], nb};
    if (ce == 4'b1110) exp_cnt++;
    e.ctrl = ce; e.vld = ev; e.cnt = exp_cnt;
    q.push_back(e);
    @(negedge iCLK);
    e = q.pop_front();
    chk({tag, ".ctrl"}, 32'(ctrl), 32'(e.ctrl));
    @(posedge iCLK);
    #1;
    chk({tag, ".valid"}, 32'(u_if.oValid), 32'(e.vld));
    chk({tag, ".cnt"}, 32'(u_if.oStallCnt), 32'(e.cnt));
    chk({tag, ".cnt2"}, 32'(u_if2.oStallCnt), 32'(e.cnt > 3 ? 3 : e.cnt));
  endtask
  task automatic drain();
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc("drain", 4'b0000, 1'b0);
  endtask
  task automatic load_use(input logic [4:0] rdl, input logic via_rs2);
    drv(1, rdl, 1, 0, 0, 0, 0, 0, 0, 0);
    cyc("ld", 4'b0000, 1'b1);
    drv(1, 5'(rdl + 1), 0, via_rs2 ? 5'd2 : rdl, 1, via_rs2 ? rdl : 5'd1, 1, 0, 0, 0);
    for (int i = 0; i < HZ_CYC; i++) cyc("haz", 4'b1110, 1'b0);
    cyc("use", 4'b0000, 1'b1);
    drain();
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
  initial begin
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1 iRST = 1'b0;
    #2;
    chk("rst.ctrl", 32'(ctrl), 32'(4'b0011));
    chk("rst.valid", 32'(u_if.oValid), 0);
    chk("rst.cnt", 32'(u_if.oStallCnt), 0);
    #9 iRST = 1'b1;
    @(posedge iCLK);
    #1;
    load_use(5'd5, 1'b0);
    chk("loaduse.cnt", 32'(u_if.oStallCnt), 32'(HZ_CYC));
    drv(1, 5'd0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc("x0.wr", 4'b0000, 1'b1);
    drv(1, 5'd14, 0, 5'd0, 1, 5'd0, 1, 0, 0, 0);
    cyc("x0.rd", 4'b0000, 1'b1);
    drain();
    drv(1, 5'd12, 1, 0, 0, 0, 0, 0, 0, 0);
    cyc("nouse.ld", 4'b0000, 1'b1);
    drv(1, 5'd15, 0, 5'd12, 0, 5'd3, 1, 0, 0, 0);
    cyc("nouse.rd", 4'b0000, 1'b1);
    drain();
    load_use(5'd13, 1'b1);
    drv(1, 5'd10, 1, 0, 0, 0, 0, 0, 0, 0);
    cyc("br.ld", 4'b0000, 1'b1);
    drv(1, 5'd17, 0, 5'd10, 1, 0, 0, 1, 0, 0);
    cyc("br.haz", 4'b0011, 1'b0);
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc("br.after", 4'b0000, 1'b0);
    drain();
    drv(1, 5'd18, 0, 0, 0, 0, 0, 0, 1, 0);
    cyc("stalli", 4'b1010, 1'b0);
    drv(1, 5'd19, 1, 0, 0, 0, 0, 0, 0, 0);
    cyc("stalli.ld", 4'b0000, 1'b1);
    drv(1, 5'd20, 0, 5'd19, 1, 0, 0, 0, 1, 0);
    cyc("stalli.haz", 4'b1110, 1'b0);
    drain();
    drv(1, 5'd7, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc("frz.a", 4'b0000, 1'b1);
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc("frz.b", 4'b0000, 1'b0);
    drv(1, 5'd8, 1, 0, 0, 0, 0, 0, 0, 0);
    cyc("frz.c", 4'b0000, 1'b1);
    drv(1, 5'd9, 0, 5'd8, 1, 0, 0, 1, 0, 1);
    for (int i = 0; i < 3; i++) cyc("frz.hold", 4'b1100, 1'b0);
    drv(1, 5'd9, 0, 5'd8, 1, 0, 0, 0, 0, 0);
    cyc("frz.release", 4'b1110, 1'b0);
    drain();
    while (exp_cnt < 7) load_use(5'd5, 1'b0);
    drv(1, 5'd21, 1, 0, 0, 0, 0, 0, 0, 0);
    cyc("arst.ld", 4'b0000, 1'b1);
    drv(1, 5'd22, 0, 5'd21, 1, 0, 0, 0, 0, 0);
    @(negedge iCLK);
    chk("arst.haz", 32'(ctrl), 32'(4'b1110));
    #1 iRST = 1'b0;
    #1;
    chk("arst.ctrl", 32'(ctrl), 32'(4'b0011));
    chk("arst.valid", 32'(u_if.oValid), 0);
    chk("arst.cnt", 32'(u_if.oStallCnt), 0);
    chk("arst.cnt2", 32'(u_if2.oStallCnt), 0);
    @(posedge iCLK);
    @(negedge iCLK);
    iRST = 1'b1;
    ev = 3'b000;
    exp_cnt = 0;
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge iCLK);
    #1;
    cyc("post.idle", 4'b0000, 1'b0);
    load_use(5'd6, 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pipe_ctrl_rv32.md
PIPE_CTRL_RV32 -- requirements
Module: pipe_ctrl_rv32

Interface
REQ-001 SHALL have parameter NSTAGES, default 5, total pipeline depth (legal 4..8; in-flight slots = NSTAGES-2).
REQ-002 SHALL have parameter REGW, default 5, register-address width.
REQ-003 SHALL have parameter CNTW, default 16, stall-counter width.
REQ-004 iCLK  in  1  the single clock; all state updates on its rising edge.
REQ-005 iRST  in  1  reset, asynchronous, active-low.
REQ-006 iIssueValid  in  1  ID holds a valid decoded instruction.
REQ-007 iIssueRs1, iIssueRs2  in  REGW  ID source register addresses.
REQ-008 iUseRs1, iUseRs2  in  1  corresponding source is actually read.
REQ-009 iIssueRd  in  REGW  ID destination address (0 = none).
REQ-010 iIssueLoad  in  1  ID instruction is a load.
REQ-011 iBranch  in  1  EX resolves a taken branch/jump this cycle.
REQ-012 iStallI, iStallD  in  1  ICache / DCache not ready.
REQ-013 oHoldIF  out  1  PC and IF register hold.
REQ-014 oHoldID  out  1  ID register holds.
REQ-015 oBubbleEX  out  1  EX receives a NOP instead of the ID instruction.
REQ-016 oFlush  out  1  IF and ID contents invalidated next edge.
REQ-017 oValid  out  NSTAGES-2  valid bit of each in-flight slot, bit 0 = EX.
REQ-018 oStallCnt  out  CNTW  saturating count of hazard-stall cycles.

Function
REQ-019 Scoreboard SHALL be a shift chain of NSTAGES-2 entries {valid, rd, load}; entry 0 = EX, last = WB.
REQ-020 When advancing, entry 0 SHALL load {iIssueValid & ~bubble & ~flush, iIssueRd, iIssueLoad}; entry k SHALL take entry k-1; the WB entry retires.
REQ-021 A source SHALL match an entry only when iUse is set, entry valid, rd equals the source address, and rd != 0.
REQ-022 FSM states RUN, HAZ, FLUSH, FRZ; reset state RUN.
REQ-023 Priority per cycle SHALL be: iStallD > iBranch > hazard > iStallI.
REQ-024 iStallD=1: next state FRZ; oHoldIF=oHoldID=1, oBubbleEX=0, scoreboard frozen, oFlush=0; iBranch ignored (EX holds it until release).
REQ-025 iBranch=1 (no iStallD): oFlush=1, oBubbleEX=1, next state FLUSH for exactly one cycle, then RUN; hazard suppressed that cycle.
REQ-026 Hazard (no iStallD, no iBranch): oHoldIF=oHoldID=1, oBubbleEX=1, scoreboard advances, oStallCnt increments, next state HAZ; HAZ returns to RUN the first cycle the hazard clears.
REQ-027 iStallI only: oHoldIF=1, oHoldID=0, oBubbleEX=1 (ID empty issued as bubble), scoreboard advances.
REQ-028 RUN with no event: all hold/bubble/flush outputs 0, scoreboard advances.
REQ-029 oHoldIF, oHoldID, oBubbleEX, oFlush SHALL be combinational from current inputs and scoreboard (zero latency); oValid and oStallCnt registered.
REQ-030 oStallCnt SHALL saturate at 2^CNTW-1, never wrap.
REQ-031 iStallD release SHALL resume in RUN with scoreboard exactly as frozen; a hazard present then is evaluated that same cycle.

Reset
REQ-032 iRST low SHALL immediately clear all scoreboard entries, oValid=0, oStallCnt=0, FSM=RUN, regardless of operation in progress.
REQ-033 During reset combinational outputs SHALL be oHoldIF=oHoldID=0, oBubbleEX=1, oFlush=1.

Configuration
REQ-034 Macro PIPE_CTRL_FWD_EN defined: bypass network exists; hazard = match against entry 0 with load=1 only (load-use, 1 stall cycle).
REQ-035 PIPE_CTRL_FWD_EN undefined: hazard = match against any valid entry except the WB entry (write-before-read register file), stalling until the producer reaches WB.

Structure
REQ-036 Shared package pipe_pkg_rv32 SHALL hold FSM state encoding, scoreboard entry typedef and default NSTAGES/REGW.
REQ-037 Sub-module sb_match_rv32 SHALL compute per-entry source-match vectors; FSM and counter stay in the top.

Verification
REQ-038 Load x5 then add x6,x5,x1 with FWD_EN -> exactly 1 cycle oHoldID=1/oBubbleEX=1, oStallCnt=1.
REQ-039 Same sequence without FWD_EN, NSTAGES=5 -> 2 stall cycles, oStallCnt=2.
REQ-040 Write x0 then read x0 -> no stall, oStallCnt=0.
REQ-041 iBranch=1 coincident with a hazard -> oFlush=1, no stall, oStallCnt unchanged, RUN after 1 cycle.
REQ-042 iStallD high 3 cycles with oValid=3'b101 -> oValid stays 3'b101, oHoldIF=oHoldID=1, resumes advancing after release.
REQ-043 iRST low mid-HAZ with oStallCnt=7 -> oValid=0, oStallCnt=0, state RUN asynchronously; CNTW=2 with 5 stall cycles -> oStallCnt=3.
